// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC generation with branch-predictor steering, a
// single-outstanding memory request FSM, and a small fetch queue feeding decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QD       = 2
) (
  input  logic        clk,
  input  logic        rst,
  // Branch predictor lookup
  output logic [31:0] bp_addr,
  input  logic        bp_hit,
  input  logic        bp_taken,
  input  logic [31:0] bp_paddr,
  // Instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // Execute-stage correction
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  // Decode queue head
  output logic        dq_valid,
  input  logic        dq_ready,
  output logic [31:0] dq_instr,
  output logic [31:0] dq_pc,
  output logic        dq_pred_taken,
  output logic [31:0] dq_pred_pc
);

  localparam int unsigned Depth    = 2 ** QD;
  localparam logic [QD:0] DepthCnt = (QD + 1)'(Depth);

  typedef enum logic [1:0] {StRun, StWait, StFlush} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   lat_pc_q, lat_pc_d;
  logic          lat_taken_q, lat_taken_d;
  logic [31:0]   lat_ppc_q, lat_ppc_d;
  logic [QD:0]   count_q, count_d;
  logic [QD-1:0] wr_ptr_q, wr_ptr_d;
  logic [QD-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] instr_mem [Depth];
  logic [31:0] pc_mem    [Depth];
  logic        taken_mem [Depth];
  logic [31:0] ppc_mem   [Depth];

  logic        push, pop;
  logic        pred_taken;
  logic [31:0] pc_plus4;

  assign pred_taken = bp_hit & bp_taken;
  assign pc_plus4   = pc_q + 32'd4;  // wraps naturally at 2**32

  assign bp_addr   = pc_q;
  assign imem_addr = pc_q;
  // rst is included so no request leaks out while reset is held
  assign imem_req  = (state_q == StRun) && (count_q < DepthCnt) && rst && !redirect;

  // Head of queue; gated by count so an empty or reset queue shows zeros
  always_comb begin
    dq_valid      = (count_q != '0);
    dq_instr      = '0;
    dq_pc         = '0;
    dq_pred_taken = 1'b0;
    dq_pred_pc    = '0;
    if (dq_valid) begin
      dq_instr      = instr_mem[rd_ptr_q];
      dq_pc         = pc_mem[rd_ptr_q];
      dq_pred_taken = taken_mem[rd_ptr_q];
      dq_pred_pc    = ppc_mem[rd_ptr_q];
    end
  end

  // Next-state: FSM, PC steering, latched prediction and queue bookkeeping
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    lat_pc_d    = lat_pc_q;
    lat_taken_d = lat_taken_q;
    lat_ppc_d   = lat_ppc_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    push        = 1'b0;
    pop         = 1'b0;

    if (redirect) begin
      // Redirect wins: flush the queue, and drop any in-flight response
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      case (state_q)
        StWait, StFlush: state_d = imem_rvalid ? StRun : StFlush;
        default:         state_d = StRun;
      endcase
    end else begin
      case (state_q)
        StRun: begin
          if (imem_req && imem_gnt) begin
            lat_pc_d    = pc_q;
            lat_taken_d = pred_taken;
            lat_ppc_d   = pred_taken ? bp_paddr : pc_plus4;
            pc_d        = pred_taken ? {bp_paddr[31:2], 2'b00} : pc_plus4;
            state_d     = StWait;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            push    = 1'b1;
            state_d = StRun;
          end
        end
        StFlush: begin
          if (imem_rvalid) state_d = StRun;
        end
        default: state_d = StRun;
      endcase

      // Push never overflows: a request is only issued when a slot is free
      pop = dq_valid && dq_ready;
      if (push) wr_ptr_d = wr_ptr_q + QD'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + QD'(1);
      if (push && !pop)      count_d = count_q + (QD + 1)'(1);
      else if (pop && !push) count_d = count_q - (QD + 1)'(1);
    end
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      pc_q        <= {RESET_PC[31:2], 2'b00};
      lat_pc_q    <= '0;
      lat_taken_q <= 1'b0;
      lat_ppc_q   <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      lat_pc_q    <= lat_pc_d;
      lat_taken_q <= lat_taken_d;
      lat_ppc_q   <= lat_ppc_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Queue storage; contents only matter once counted, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= lat_pc_q;
      taken_mem[wr_ptr_q] <= lat_taken_q;
      ppc_mem[wr_ptr_q]   <= lat_ppc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int          QDepth  = 4;

  logic        clk;
  logic        rst;
  logic [31:0] bp_addr;
  logic        bp_hit, bp_taken;
  logic [31:0] bp_paddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dq_valid, dq_ready;
  logic [31:0] dq_instr, dq_pc;
  logic        dq_pred_taken;
  logic [31:0] dq_pred_pc;

  fetch_unit #(
    .RESET_PC (ResetPc),
    .QD       (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bp_addr       (bp_addr),
    .bp_hit        (bp_hit),
    .bp_taken      (bp_taken),
    .bp_paddr      (bp_paddr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .dq_valid      (dq_valid),
    .dq_ready      (dq_ready),
    .dq_instr      (dq_instr),
    .dq_pc         (dq_pc),
    .dq_pred_taken (dq_pred_taken),
    .dq_pred_pc    (dq_pred_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] ppc;
  } ent_t;

  // Reference model: next fetch address, the one in-flight fetch, and the
  // stream of instructions decode should see, in order.
  ent_t        exp_q[$];
  ent_t        pend;
  logic [31:0] m_pc;
  bit          outstanding;
  bit          flushing;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Hold reset low for n cycles, checking that all outputs are quiet
  task automatic do_reset(input int n);
    rst         = 1'b0;
    m_pc        = ResetPc;
    outstanding = 1'b0;
    flushing    = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_dq_valid", dq_valid, 1'b0);
      chk("rst_dq_instr", dq_instr, 32'h0);
      chk("rst_dq_pc", dq_pc, 32'h0);
      chk("rst_dq_pred_taken", dq_pred_taken, 1'b0);
      chk("rst_dq_pred_pc", dq_pred_pc, 32'h0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model
  task automatic run_cycle(input bit rdy, input bit gnt, input bit rv,
                           input bit redir = 1'b0, input logic [31:0] rpc = 32'h0,
                           input bit hit = 1'b0, input bit tkn = 1'b0,
                           input logic [31:0] tgt = 32'h0);
    bit   exp_req, fire, pop;
    ent_t head;
    dq_ready    = rdy;
    imem_gnt    = gnt;
    imem_rvalid = rv;
    redirect    = redir;
    redirect_pc = rpc;
    bp_hit      = hit;
    bp_taken    = tkn;
    bp_paddr    = tgt;
    imem_rdata  = outstanding ? pend.instr : 32'hDEAD_BEEF;

    @(negedge clk);
    exp_req = !outstanding && (exp_q.size() < QDepth) && !redir;
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("bp_addr", bp_addr, m_pc);
    chk("dq_valid", dq_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("dq_instr", dq_instr, head.instr);
      chk("dq_pc", dq_pc, head.pc);
      chk("dq_pred_taken", dq_pred_taken, head.taken);
      chk("dq_pred_pc", dq_pred_pc, head.ppc);
    end
    fire = exp_req && gnt;
    pop  = (exp_q.size() != 0) && rdy && !redir;

    @(posedge clk);
    #1;
    if (redir) begin
      m_pc = {rpc[31:2], 2'b00};
      exp_q.delete();
      if (outstanding) begin
        if (rv) begin
          outstanding = 1'b0;
          flushing    = 1'b0;
        end else begin
          flushing = 1'b1;
        end
      end
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (outstanding && rv) begin
        if (!flushing) exp_q.push_back(pend);
        outstanding = 1'b0;
        flushing    = 1'b0;
      end else if (fire) begin
        pend.pc     = m_pc;
        pend.instr  = instr_of(m_pc);
        pend.taken  = hit && tkn;
        pend.ppc    = (hit && tkn) ? tgt : m_pc + 32'd4;
        outstanding = 1'b1;
        m_pc        = (hit && tkn) ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    rst         = 1'b0;
    dq_ready    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    bp_hit      = 1'b0;
    bp_taken    = 1'b0;
    bp_paddr    = '0;
    outstanding = 1'b0;
    flushing    = 1'b0;
    pend        = '{instr: 32'h0, pc: 32'h0, taken: 1'b0, ppc: 32'h0};
    m_pc        = ResetPc;

    do_reset(3);

    // Sequential fetches 0x0, 0x4, then 0x8 predicted taken to 0x100
    run_cycle(0, 1, 0);
    run_cycle(0, 1, 1);
    run_cycle(0, 1, 0);
    run_cycle(0, 1, 1);
    run_cycle(0, 1, 0, 0, 32'h0, 1, 1, 32'h0000_0100);
    run_cycle(0, 1, 1);
    run_cycle(0, 1, 0);
    run_cycle(0, 0, 1);
    // Queue full: no requests until a pop, then exactly one more fetch
    repeat (3) run_cycle(0, 1, 0);
    run_cycle(1, 1, 0);
    run_cycle(0, 1, 0);
    run_cycle(0, 1, 1);
    repeat (2) run_cycle(0, 1, 0);
    // Request held without grant
    run_cycle(1, 0, 0);
    repeat (2) run_cycle(0, 0, 0);
    run_cycle(0, 1, 0);
    run_cycle(0, 1, 1);
    repeat (5) run_cycle(1, 0, 0);

    // Redirect to misaligned 0x203 while waiting; late response dropped
    run_cycle(0, 1, 0);
    run_cycle(0, 0, 0, 1, 32'h0000_0203);
    run_cycle(0, 1, 1);
    run_cycle(0, 1, 0);
    run_cycle(0, 1, 1);

    // Redirect coinciding with response and pop
    run_cycle(0, 1, 0);
    run_cycle(1, 1, 1, 1, 32'h0000_0400);
    run_cycle(0, 1, 0);
    run_cycle(0, 1, 1);

    // PC wrap at the top of the address space
    run_cycle(0, 0, 0, 1, 32'hFFFF_FFFE);
    run_cycle(0, 1, 0);
    run_cycle(0, 1, 1);
    run_cycle(1, 1, 0);
    run_cycle(0, 1, 1);
    run_cycle(1, 0, 0);

    // Reset while a fetch is outstanding; stale response after release ignored
    run_cycle(0, 1, 0);
    do_reset(2);
    run_cycle(0, 1, 1);
    run_cycle(0, 1, 1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bit          r_rdy, r_gnt, r_rv, r_redir, r_hit, r_tkn;
      logic [31:0] r_rpc, r_tgt;
      r_rdy   = ($urandom % 4) != 0;
      r_gnt   = ($urandom % 3) != 0;
      r_rv    = outstanding ? ($urandom % 2) == 0 : ($urandom % 8) == 0;
      r_redir = ($urandom % 25) == 0;
      r_rpc   = $urandom & 32'h0000_0FFF;
      r_hit   = ($urandom % 2) == 0;
      r_tkn   = ($urandom % 2) == 0;
      r_tgt   = ($urandom % 4096) & 32'hFFFF_FFFC;
      run_cycle(r_rdy, r_gnt, r_rv, r_redir, r_rpc, r_hit, r_tkn, r_tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
